// File: rtl/bulls_cows_pkg.sv
// rtl/bulls_cows_pkg.sv - shared states, display glyphs and bulls/cows scoring for bulls_cows_n
package bulls_cows_pkg;

  typedef enum logic [2:0] {SET1, SET2, GUESS, RESULT, WIN, DRAW, ERR} state_e;

  typedef logic [5:0] disp_t;

  localparam disp_t DISP_BLANK = 6'b100000;

  // Only 16 glyph values exist: S and U reuse the lookalike digits 5 and 0.
  localparam logic [3:0] G_U    = 4'h0;
  localparam logic [3:0] G_S    = 4'h5;
  localparam logic [3:0] G_P    = 4'hA;
  localparam logic [3:0] G_b    = 4'hB;
  localparam logic [3:0] G_c    = 4'hC;
  localparam logic [3:0] G_d    = 4'hD;
  localparam logic [3:0] G_E    = 4'hE;
  localparam logic [3:0] G_DASH = 4'hF;

  function automatic disp_t glyph(input logic [3:0] g);
    return {1'b0, g, 1'b0};
  endfunction

  // Returns {cows, bulls}; only the low n digits of s and g take part.
  function automatic logic [15:0] bc_score(input logic [31:0] s, input logic [31:0] g, input int n);
    logic [7:0] b;
    logic [7:0] c;
    b = '0;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i < n && j < n && s[4*i +: 4] == g[4*j +: 4]) begin
          if (i == j) b = b + 8'd1;
          else        c = c + 8'd1;
        end
      end
    end
    return {c, b};
  endfunction

endpackage

// File: rtl/bulls_cows_n_enter_edge.sv
// rtl/bulls_cows_n_enter_edge.sv - rising-edge detector producing a one-cycle enter event
module enter_edge (
  input  logic clock,
  input  logic reset,
  input  logic enter,
  output logic pulse
);

  logic hist;

  // History resets high so a button held through reset release is not an event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      hist  <= enter;
      pulse <= enter & ~hist;
    end
  end

endmodule

// File: rtl/bulls_cows_n.sv
// rtl/bulls_cows_n.sv - two-player bulls and cows game; define BC_DUP_CHECK_EN to reject repeated digits
module bulls_cows_n
  import bulls_cows_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MAX_TRIES = 10
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [4*DIGITS-1:0]               sw,
  input  logic                              enter,
  output logic [47:0]                       disp,
  output logic                              p1_win,
  output logic                              p2_win,
  output logic                              draw,
  output logic                              err,
  output logic [2*$clog2(MAX_TRIES+2)-1:0]  tries
);

  localparam int TW = $clog2(MAX_TRIES + 2);
  localparam int CW = $clog2(DIGITS + 1) + 1;

  state_e                state;
  state_e                ret_state;
  logic [4*DIGITS-1:0]   secret1;
  logic [4*DIGITS-1:0]   secret2;
  logic [TW-1:0]         tries_p1;
  logic [TW-1:0]         tries_p2;
  logic                  turn;
  logic [CW-1:0]         bulls;
  logic [CW-1:0]         cows;
  logic                  ev;
  logic                  entry_ok;
  logic [4*DIGITS-1:0]   opp;
  logic [15:0]           score;
  logic [CW-1:0]         bulls_n;
  logic [CW-1:0]         cows_n;

  enter_edge u_edge (
    .clock (clock),
    .reset (reset),
    .enter (enter),
    .pulse (ev)
  );

  function automatic logic entry_valid(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
`ifdef BC_DUP_CHECK_EN
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = i + 1; j < DIGITS; j++) begin
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
      end
    end
`endif
    return ok;
  endfunction

  assign entry_ok = entry_valid(sw);
  assign opp      = turn ? secret1 : secret2;
  assign score    = bc_score(32'(opp), 32'(sw), DIGITS);
  assign bulls_n  = CW'(score[7:0]);
  assign cows_n   = CW'(score[15:8]);
  assign tries    = {tries_p2, tries_p1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SET1;
      ret_state <= SET1;
      secret1   <= '0;
      secret2   <= '0;
      tries_p1  <= '0;
      tries_p2  <= '0;
      turn      <= 1'b0;
      bulls     <= '0;
      cows      <= '0;
      p1_win    <= 1'b0;
      p2_win    <= 1'b0;
      draw      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (ev) begin
        case (state)
          SET1, SET2: begin
            if (!entry_ok) begin
              err       <= 1'b1;
              ret_state <= state;
              state     <= ERR;
            end else if (state == SET1) begin
              secret1 <= sw;
              state   <= SET2;
            end else begin
              secret2 <= sw;
              turn    <= 1'b0;
              state   <= GUESS;
            end
          end
          GUESS: begin
            if (!entry_ok) begin
              err       <= 1'b1;
              ret_state <= GUESS;
              state     <= ERR;
            end else begin
              bulls <= bulls_n;
              cows  <= cows_n;
              if (turn) tries_p2 <= tries_p2 + 1'b1;
              else      tries_p1 <= tries_p1 + 1'b1;
              if (bulls_n == CW'(DIGITS)) begin
                p1_win <= ~turn;
                p2_win <= turn;
                state  <= WIN;
              end else begin
                state <= RESULT;
              end
            end
          end
          RESULT: begin
            if (MAX_TRIES != 0 && tries_p2 == TW'(MAX_TRIES) && turn) begin
              draw  <= 1'b1;
              state <= DRAW;
            end else begin
              turn  <= ~turn;
              state <= GUESS;
            end
          end
          WIN, DRAW: begin
            secret1  <= '0;
            secret2  <= '0;
            tries_p1 <= '0;
            tries_p2 <= '0;
            turn     <= 1'b0;
            bulls    <= '0;
            cows     <= '0;
            p1_win   <= 1'b0;
            p2_win   <= 1'b0;
            draw     <= 1'b0;
            state    <= SET1;
          end
          ERR:     state <= ret_state;
          default: state <= SET1;
        endcase
      end
    end
  end

  always_comb begin
    disp = {8{DISP_BLANK}};
    case (state)
      SET1, SET2: begin
        disp[5:0]   = glyph(G_U);
        disp[11:6]  = glyph(G_S);
        disp[17:12] = glyph(G_DASH);
        disp[23:18] = glyph((state == SET2) ? 4'd2 : 4'd1);
        disp[29:24] = glyph(G_P);
      end
      GUESS: begin
        disp[5:0]   = glyph(4'd6);
        disp[11:6]  = glyph(G_DASH);
        disp[17:12] = glyph(turn ? 4'd2 : 4'd1);
        disp[23:18] = glyph(G_P);
      end
      RESULT: begin
        disp[5:0]   = glyph(4'(bulls));
        disp[11:6]  = glyph(G_b);
        disp[23:18] = glyph(4'(cows));
        disp[29:24] = glyph(G_c);
      end
      WIN: begin
        disp[5:0]   = glyph(G_E);
        disp[11:6]  = glyph(G_DASH);
        disp[17:12] = glyph(p2_win ? 4'd2 : 4'd1);
      end
      DRAW:    disp[5:0] = glyph(G_d);
      ERR:     disp[5:0] = glyph(G_E);
      default: disp = {8{DISP_BLANK}};
    endcase
  end

endmodule

// File: tb/tb_bulls_cows_n.sv
// tb/tb_bulls_cows_n.sv - self-checking bench for bulls_cows_n (DIGITS=4, MAX_TRIES=2)
module tb_bulls_cows_n;
  import bulls_cows_pkg::*;

  localparam int DIG  = 4;
  localparam int MAXT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b0;
  logic [15:0] sw    = '0;
  logic [47:0] disp;
  logic        p1_win, p2_win, draw, err;
  logic [3:0]  tries;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bulls_cows_n #(.DIGITS(DIG), .MAX_TRIES(MAXT)) dut (
    .clock(clock), .reset(reset), .sw(sw), .enter(enter), .disp(disp),
    .p1_win(p1_win), .p2_win(p2_win), .draw(draw), .err(err), .tries(tries)
  );

  localparam disp_t BL = DISP_BLANK;

  function automatic disp_t gc(input int v);
    return {1'b0, 4'(v), 1'b0};
  endfunction

  function automatic logic [47:0] pat(input disp_t a, b, c, d, e);
    return {BL, BL, BL, e, d, c, b, a};
  endfunction

  function automatic logic [47:0] pat_set(input int n);
    return pat(gc(G_U), gc(G_S), gc(G_DASH), gc(n), gc(G_P));
  endfunction
  function automatic logic [47:0] pat_guess(input int n);
    return pat(gc(6), gc(G_DASH), gc(n), gc(G_P), BL);
  endfunction
  function automatic logic [47:0] pat_res(input int b, input int c);
    return pat(gc(b), gc(G_b), BL, gc(c), gc(G_c));
  endfunction
  function automatic logic [47:0] pat_win(input int n);
    return pat(gc(G_E), gc(G_DASH), gc(n), BL, BL);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Game-level reference model working on digit arrays.
  localparam int M_SET1 = 0, M_SET2 = 1, M_GUESS = 2, M_RESULT = 3, M_WIN = 4, M_DRAW = 5, M_ERR = 6;
  int   m_ph, m_ret, m_turn, m_win, m_b, m_c;
  int   m_sec [2][DIG];
  int   m_tries [2];
  logic m_err;

  task automatic model_reset();
    m_ph = M_SET1; m_ret = M_SET1; m_turn = 0; m_win = 0; m_b = 0; m_c = 0; m_err = 1'b0;
    m_tries[0] = 0; m_tries[1] = 0;
    for (int p = 0; p < 2; p++) for (int i = 0; i < DIG; i++) m_sec[p][i] = 0;
  endtask

  function automatic bit m_valid(input logic [15:0] v);
    int d [DIG];
    for (int i = 0; i < DIG; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > 9) return 1'b0;
    end
`ifdef BC_DUP_CHECK_EN
    for (int i = 0; i < DIG; i++)
      for (int j = 0; j < DIG; j++)
        if (i != j && d[i] == d[j]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic model_step(input logic [15:0] v);
    int g [DIG];
    int opp;
    bit ok;
    ok = m_valid(v);
    m_err = 1'b0;
    for (int i = 0; i < DIG; i++) g[i] = int'(v[4*i +: 4]);
    case (m_ph)
      M_SET1, M_SET2: begin
        if (ok) begin
          for (int i = 0; i < DIG; i++) m_sec[m_ph][i] = g[i];
          m_ph   = (m_ph == M_SET1) ? M_SET2 : M_GUESS;
          m_turn = 0;
        end else begin
          m_err = 1'b1; m_ret = m_ph; m_ph = M_ERR;
        end
      end
      M_ERR: m_ph = m_ret;
      M_GUESS: begin
        if (!ok) begin
          m_err = 1'b1; m_ret = m_ph; m_ph = M_ERR;
        end else begin
          opp = 1 - m_turn; m_b = 0; m_c = 0;
          for (int i = 0; i < DIG; i++)
            for (int j = 0; j < DIG; j++)
              if (m_sec[opp][i] == g[j]) begin
                if (i == j) m_b++;
                else        m_c++;
              end
          m_tries[m_turn]++;
          if (m_b == DIG) begin m_win = m_turn + 1; m_ph = M_WIN; end
          else m_ph = M_RESULT;
        end
      end
      M_RESULT: begin
        if (MAXT != 0 && m_tries[1] == MAXT && m_turn == 1) m_ph = M_DRAW;
        else begin m_turn = 1 - m_turn; m_ph = M_GUESS; end
      end
      default: model_reset();
    endcase
  endtask

  function automatic logic [47:0] m_disp();
    case (m_ph)
      M_SET1:   return pat_set(1);
      M_SET2:   return pat_set(2);
      M_GUESS:  return pat_guess(m_turn + 1);
      M_RESULT: return pat_res(m_b % 16, m_c % 16);
      M_WIN:    return pat_win(m_win);
      M_DRAW:   return pat(gc(G_d), BL, BL, BL, BL);
      default:  return pat(gc(G_E), BL, BL, BL, BL);
    endcase
  endfunction

  function automatic logic [2:0] m_flags();
    return {m_ph == M_WIN && m_win == 1, m_ph == M_WIN && m_win == 2, m_ph == M_DRAW};
  endfunction

  task automatic apply(input logic [15:0] v);
    @(negedge clock); sw = v; enter = 1'b1;
    @(negedge clock); enter = 1'b0;
    @(negedge clock);
  endtask

  task automatic mcheck(input logic [15:0] v, input string tag);
    model_step(v);
    chk({tag, " disp"},  disp, m_disp());
    chk({tag, " tries"}, tries, {2'(m_tries[1]), 2'(m_tries[0])});
    chk({tag, " flags"}, {p1_win, p2_win, draw, err}, {m_flags(), m_err});
    @(negedge clock);
    chk({tag, " hold"},  {p1_win, p2_win, draw, err, disp}, {m_flags(), 1'b0, m_disp()});
  endtask

  task automatic press(input logic [15:0] v, input string tag);
    apply(v);
    mcheck(v, tag);
  endtask

  function automatic logic [15:0] rnd_entry(input bit distinct);
    logic [15:0] v;
    logic [9:0]  used;
    int d;
    v = '0; used = '0;
    for (int i = 0; i < DIG; i++) begin
      do d = int'($urandom_range(0, 9)); while (distinct && used[d]);
      used[d] = 1'b1;
      v[4*i +: 4] = 4'(d);
    end
    return v;
  endfunction

  typedef struct {
    logic [15:0] sw;
    logic [47:0] disp;
    logic [3:0]  tries;
    logic [3:0]  flags;   // {p1_win, p2_win, draw, err}
  } vec_t;

  function automatic vec_t mk(input logic [15:0] s, input logic [47:0] d, input logic [3:0] t, input logic [3:0] f);
    vec_t r;
    r.sw = s; r.disp = d; r.tries = t; r.flags = f;
    return r;
  endfunction

  vec_t        tbl [14];
  logic [15:0] v;
  logic [47:0] perr;

  initial begin
    perr = pat(gc(G_E), BL, BL, BL, BL);
    tbl[0]  = mk(16'h1234, pat_set(2),    4'h0, 4'b0000);
    tbl[1]  = mk(16'h12A4, perr,          4'h0, 4'b0001);
    tbl[2]  = mk(16'h0000, pat_set(2),    4'h0, 4'b0000);
    tbl[3]  = mk(16'h5678, pat_guess(1),  4'h0, 4'b0000);
    tbl[4]  = mk(16'h8765, pat_res(0, 4), 4'h1, 4'b0000);
    tbl[5]  = mk(16'h0000, pat_guess(2),  4'h1, 4'b0000);
    tbl[6]  = mk(16'h1243, pat_res(2, 2), 4'h5, 4'b0000);
    tbl[7]  = mk(16'h0000, pat_guess(1),  4'h5, 4'b0000);
    tbl[8]  = mk(16'h1A00, perr,          4'h5, 4'b0001);
    tbl[9]  = mk(16'h0000, pat_guess(1),  4'h5, 4'b0000);
    tbl[10] = mk(16'h5678, pat_win(1),    4'h6, 4'b1000);
    tbl[11] = mk(16'h0000, pat_set(1),    4'h0, 4'b0000);
`ifdef BC_DUP_CHECK_EN
    tbl[12] = mk(16'h1123, perr,          4'h0, 4'b0001);
    tbl[13] = mk(16'h0000, pat_set(1),    4'h0, 4'b0000);
`else
    tbl[12] = mk(16'h1123, pat_set(2),    4'h0, 4'b0000);
    tbl[13] = mk(16'h0000, pat_guess(1),  4'h0, 4'b0000);
`endif

    // Reset state, during and after reset.
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst disp",  disp, pat_set(1));
    chk("rst outs",  {p1_win, p2_win, draw, err, tries}, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    chk("post rst disp", disp, pat_set(1));

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].sw);
      chk($sformatf("tbl%0d disp", i),  disp, tbl[i].disp);
      chk($sformatf("tbl%0d tries", i), tries, tbl[i].tries);
      chk($sformatf("tbl%0d flags", i), {p1_win, p2_win, draw, err}, tbl[i].flags);
      mcheck(tbl[i].sw, $sformatf("tbl%0d model", i));
    end

    // Draw after both players use MAX_TRIES wrong guesses.
    @(negedge clock); reset = 1'b0; @(negedge clock); reset = 1'b1; model_reset();
    press(16'h1234, "draw s1");
    press(16'h5678, "draw s2");
    for (int k = 0; k < 4; k++) begin
      press(16'h9012, "draw guess");
      if (k < 3) press(16'h0000, "draw next");
    end
    apply(16'h0000);
    chk("draw flag",  {draw, p1_win, p2_win}, 3'b100);
    chk("draw tries", tries, 4'b1010);
    mcheck(16'h0000, "draw model");
    press(16'h0000, "draw exit");

    // Reset with enter held, then release with enter still high.
    press(16'h1234, "hold s1");
    press(16'h5678, "hold s2");
    @(negedge clock); sw = 16'h1234; enter = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("hold rst disp", disp, pat_set(1));
    chk("hold rst outs", {p1_win, p2_win, draw, err, tries}, 8'h00);
    @(negedge clock); reset = 1'b1; model_reset();
    repeat (4) @(negedge clock);
    chk("hold no event", {err, disp}, {1'b0, pat_set(1)});
    enter = 1'b0;
    press(16'h1234, "hold repress");

    // Randomized play against the model.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        v = rnd_entry(1'b0);
        v[4*int'($urandom_range(0, 3)) +: 4] = 4'(10 + $urandom_range(0, 5));
      end else if (r < 4 && m_ph == M_GUESS) begin
        for (int i = 0; i < DIG; i++) v[4*i +: 4] = 4'(m_sec[1 - m_turn][i]);
      end else begin
        v = rnd_entry(r < 8);
      end
      press(v, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bulls_cows_n.md
BULLS_COWS_N -- requirements
Module: bulls_cows_n

Interface
REQ-001 Parameter DIGITS, default 4, is the number of code digits per secret/guess (2..8).
REQ-002 Parameter MAX_TRIES, default 10, is the guess limit per player; 0 means unlimited.
REQ-003 Port clock  input  1  is the single rising-edge clock.
REQ-004 Port reset  input  1  is the asynchronous, active-low reset.
REQ-005 Port sw  input  4*DIGITS  is the entry value, 4 bits per digit; digit 0 is bits [3:0].
REQ-006 Port enter  input  1  is the raw enter button; only its rising edge acts.
REQ-007 Port disp  output  48  holds eight 6-bit display codes; d1 (leftmost) is disp[5:0].
REQ-008 Port p1_win  output  1  is held high while in WIN with winner player 1.
REQ-009 Port p2_win  output  1  is held high while in WIN with winner player 2.
REQ-010 Port draw  output  1  is held high while in DRAW.
REQ-011 Port err  output  1  pulses high for exactly one cycle when an entry is rejected.
REQ-012 Port tries  output  2*$clog2(MAX_TRIES+2)  holds {tries_p2, tries_p1}, the completed guesses per player.

Function
REQ-013 States SHALL be SET1, SET2, GUESS, RESULT, WIN, DRAW and ERR.
REQ-014 An "enter event" SHALL be a one-cycle pulse on the cycle after enter goes 0->1, registered inside the block.
REQ-015 On an enter event in SET1/SET2, a valid sw SHALL be latched as secret1/secret2, with transition SET1->SET2 or SET2->GUESS (turn=P1).
REQ-016 An entry SHALL be valid iff every digit is <=9, plus the duplicate rule of REQ-030.
REQ-017 An invalid entry in SET1, SET2 or GUESS SHALL:
  - pulse err;
  - store the originating state and enter ERR;
  - not latch the entry and not count a try.
REQ-018 In ERR, the next enter event SHALL return to the stored state.
REQ-019 In GUESS, a valid enter event SHALL compare sw with the opponent's secret (P1 vs secret2, P2 vs secret1).
REQ-020 The same enter event SHALL register the bulls and cows counts and increment the current player's try counter.
REQ-021 Bulls SHALL count positions i with s[i]==g[i].
REQ-022 Cows SHALL count pairs (i,j), i!=j, with s[i]==g[j].
REQ-023 Counts SHALL be $clog2(DIGITS+1)+1 bits wide and are computed combinationally, so RESULT displays them on the cycle after the enter event.
REQ-024 If bulls==DIGITS, the block SHALL go to WIN with winner = current player; otherwise to RESULT.
REQ-025 In RESULT, on an enter event:
  - if MAX_TRIES!=0 and tries_p2==MAX_TRIES and turn==P2, go to DRAW;
  - otherwise toggle turn and return to GUESS.
REQ-026 In WIN or DRAW, an enter event SHALL clear the secrets, tries and turn, and go to SET1.
REQ-027 Display codes: bit5=1 blanks the digit; bits4:1 are the glyph value; bit0 is the decimal point.
  - SETn: "U S - n P" in d1..d5.
  - GUESS: "6 - n P" in d1..d4.
  - RESULT: bulls "b" blank cows "c" in d1..d5.
  - WIN: "E - n" in d1..d3.
  - DRAW: "d" in d1.
  - ERR: "E" in d1.
  - All unused digits are blank.
REQ-028 An enter event coincident with an in-progress state change SHALL be impossible, because events are single-cycle and each state acts once per event.

Reset
REQ-029 While reset=0, the block SHALL hold:
  - state=SET1, secrets=0, tries=0, turn=P1, counts=0;
  - p1_win=p2_win=draw=err=0;
  - disp showing the SET1 pattern;
  - the edge detector history = 1, so that a button held through reset release does not generate an event.
Reset mid-game discards all game data.

Configuration
REQ-030 With macro BC_DUP_CHECK_EN defined, an entry containing any repeated digit SHALL be invalid, for both secrets and guesses; without it, repeated digits SHALL be accepted and only the range check applies.

Structure
REQ-031 Package bulls_cows_pkg SHALL hold:
  - the state enum;
  - the display glyph constants (DISP_BLANK, G_U, G_S, G_P, G_b, G_c, G_E, G_d, G_DASH);
  - the 6-bit display code typedef.
REQ-032 Edge detection SHALL be a separate sub-module named enter_edge; the bulls/cows counting SHALL be a function inside the package.

Verification
REQ-033 Secrets 0x1234/0x5678, then P1 guesses 0x5678 -> one cycle later state WIN, p1_win=1 held, disp d3=1, tries_p1=1.
REQ-034 secret2=0x5678, P1 guesses 0x8765 -> RESULT with bulls=0 and cows=4 (d1 glyph 0, d4 glyph 4); the next enter selects the P2 guess.
REQ-035 SET1 entry 0x1123 -> with BC_DUP_CHECK_EN, a single-cycle err pulse and ERR, then the next enter returns to SET1 with secret1 unchanged; without the macro it is accepted and the block goes to SET2.
REQ-036 SET2 entry 0x12A4 -> err pulse and ERR regardless of the macro.
REQ-037 MAX_TRIES=2 with all guesses wrong -> after P2's second RESULT plus enter, draw=1 and tries={2,2}.
REQ-038 Assert reset in GUESS with enter held high and release it -> state SET1, all outputs at reset values, and no enter event until enter is released and pressed again.
